// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, FSM states, ALU functions and next-PC selects.
// The datapath and ALU import the same constants so every decoder agrees on them.
package multicycle_control_unit_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_BEQ    = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_RS     = 2'b10;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
           (op == OP_AND) || (op == OP_SLL) || (op == OP_SLT);
  endfunction

  function automatic logic is_alu_op(input logic [5:0] op);
    return is_rtype(op) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_SLL:         return ALU_SLL;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_SLT:         return ALU_SLT;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_control_decode.sv
// Pure combinational decode of (state, opcode, zero) into every datapath enable and select.
// Zero latency, no handshake; unlisted enables/selects default to 0.
module control_decode
  import multicycle_control_unit_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  output logic       o_pc_wre,
  output logic       o_ir_wre,
  output logic       o_ins_mem_rw,
  output logic       o_m_rd,
  output logic       o_m_wr,
  output logic       o_reg_wre,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic       o_ext_sel,
  output logic       o_db_data_src,
  output logic       o_wr_reg_data,
  output logic       o_reg_dst,
  output logic       o_reg_dst31,
  output logic [1:0] o_pc_src,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_pc_wre      = 1'b0;
    o_ir_wre      = 1'b0;
    o_ins_mem_rw  = 1'b0;
    o_m_rd        = 1'b0;
    o_m_wr        = 1'b0;
    o_reg_wre     = 1'b0;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 1'b0;
    o_ext_sel     = 1'b0;
    o_db_data_src = 1'b0;
    o_wr_reg_data = 1'b0;
    o_reg_dst     = 1'b0;
    o_reg_dst31   = 1'b0;
    o_pc_src      = PC_SRC_SEQ;
    o_alu_op      = ALU_ADD;

    case (i_state)
      S_IF: begin
        o_ins_mem_rw = 1'b1;
        o_ir_wre     = 1'b1;
      end
      S_ID: begin
        case (i_opcode)
          OP_J: begin
            o_pc_wre = 1'b1;
            o_pc_src = PC_SRC_JUMP;
          end
          OP_JR: begin
            o_pc_wre = 1'b1;
            o_pc_src = PC_SRC_RS;
          end
          OP_JAL: begin
            o_pc_wre      = 1'b1;
            o_pc_src      = PC_SRC_JUMP;
            o_reg_wre     = 1'b1;
            o_wr_reg_data = 1'b1;
            o_reg_dst31   = 1'b1;
          end
          OP_HALT: ;  // PC never advances, so halt is re-fetched forever
          default: begin
            // Undefined opcodes retire as a NOP; real ops continue to later states
            if (!is_alu_op(i_opcode) && (i_opcode != OP_LW) &&
                (i_opcode != OP_SW) && (i_opcode != OP_BEQ)) begin
              o_pc_wre = 1'b1;
              o_pc_src = PC_SRC_SEQ;
            end
          end
        endcase
      end
      S_EXE_AL: begin
        o_alu_src_b = (i_opcode == OP_ADDI) || (i_opcode == OP_ORI);
        o_ext_sel   = (i_opcode == OP_ADDI);
        o_alu_src_a = (i_opcode == OP_SLL);
        o_alu_op    = alu_op_for(i_opcode);
      end
      S_WB_AL: begin
        o_reg_wre = 1'b1;
        o_reg_dst = is_rtype(i_opcode);
        o_pc_wre  = 1'b1;
      end
      S_EXE_LS: begin
        o_alu_src_b = 1'b1;
        o_ext_sel   = 1'b1;
      end
      S_MEM: begin
        if (i_opcode == OP_LW) begin
          o_m_rd = 1'b1;
        end else begin
          o_m_wr   = 1'b1;
          o_pc_wre = 1'b1;
        end
      end
      S_WB_L: begin
        o_reg_wre     = 1'b1;
        o_db_data_src = 1'b1;
        o_pc_wre      = 1'b1;
      end
      S_BEQ: begin
        o_alu_op  = ALU_SUB;
        o_ext_sel = 1'b1;
        o_pc_wre  = 1'b1;
        o_pc_src  = i_zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: one state per cycle, outputs decoded combinationally from state+opcode.
// No handshake; synchronous Reset returns to IF and holds every write/read enable low.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  output logic [2:0] o_state,
  output logic       o_pc_wre,
  output logic       o_ir_wre,
  output logic       o_ins_mem_rw,
  output logic       o_m_rd,
  output logic       o_m_wr,
  output logic       o_reg_wre,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic       o_ext_sel,
  output logic       o_db_data_src,
  output logic       o_wr_reg_data,
  output logic       o_reg_dst,
  output logic       o_reg_dst31,
  output logic [1:0] o_pc_src,
  output logic [2:0] o_alu_op
);

  state_t r_state;
  state_t w_next_state;
  logic   w_pc_wre, w_ir_wre, w_ins_mem_rw, w_m_rd, w_m_wr, w_reg_wre;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IF;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        if (is_alu_op(i_opcode))                            w_next_state = S_EXE_AL;
        else if ((i_opcode == OP_LW) || (i_opcode == OP_SW)) w_next_state = S_EXE_LS;
        else if (i_opcode == OP_BEQ)                         w_next_state = S_BEQ;
        else                                                 w_next_state = S_IF;
      end
      S_EXE_AL: w_next_state = S_WB_AL;
      S_EXE_LS: w_next_state = S_MEM;
      S_MEM:    w_next_state = (i_opcode == OP_LW) ? S_WB_L : S_IF;
      default:  w_next_state = S_IF;
    endcase
  end

  control_decode u_decode (
    .i_state       (r_state),
    .i_opcode      (i_opcode),
    .i_zero        (i_zero),
    .o_pc_wre      (w_pc_wre),
    .o_ir_wre      (w_ir_wre),
    .o_ins_mem_rw  (w_ins_mem_rw),
    .o_m_rd        (w_m_rd),
    .o_m_wr        (w_m_wr),
    .o_reg_wre     (w_reg_wre),
    .o_alu_src_a   (o_alu_src_a),
    .o_alu_src_b   (o_alu_src_b),
    .o_ext_sel     (o_ext_sel),
    .o_db_data_src (o_db_data_src),
    .o_wr_reg_data (o_wr_reg_data),
    .o_reg_dst     (o_reg_dst),
    .o_reg_dst31   (o_reg_dst31),
    .o_pc_src      (o_pc_src),
    .o_alu_op      (o_alu_op)
  );

  // Reset abandons the in-flight instruction, so no state element may be written meanwhile
  assign o_pc_wre     = w_pc_wre     & ~i_reset;
  assign o_ir_wre     = w_ir_wre     & ~i_reset;
  assign o_ins_mem_rw = w_ins_mem_rw & ~i_reset;
  assign o_m_rd       = w_m_rd       & ~i_reset;
  assign o_m_wr       = w_m_wr       & ~i_reset;
  assign o_reg_wre    = w_reg_wre    & ~i_reset;
  assign o_state      = r_state;

endmodule
